dbg_host: RTL and testbench

Debug-bus initiator: converts a host byte stream (UART/AXI-stream bridge) into single-beat and burst accesses on the debug bus (`dbg_addr`/`dbg_wen`/`dbg_wdata`/`dbg_rdata`). It drives the same bus the debug controller and ROM loader respond to. Read data and write acknowledges are returned as a byte stream. Used by the host to load ROM, toggle the system reset bits and sample CPU state (PC, instruction, index registers).

---
 rtl/dbg_host.sv | 147 ++++++++++++++
 tb/tb_dbg_host.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_host.sv
// Debug-bus initiator: turns a host byte stream into single/burst debug-bus
// accesses and returns read data or a write acknowledge as a byte stream.
module dbg_host #(
    parameter int unsigned SEG_W    = 2,
    parameter int unsigned OFS_W    = 12,
    parameter int unsigned PARK_SEG = 0,
    parameter logic [7:0]  ACK_BYTE = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEG_W+OFS_W-1:0] dbg_addr,
    output logic                   dbg_wen,
    output logic [7:0]             dbg_wdata,
    input  logic [7:0]             dbg_rdata,
    output logic                   busy
);

    localparam int unsigned AW = SEG_W + OFS_W;
    localparam logic [AW-1:0] PARK_ADDR = {SEG_W'(PARK_SEG), OFS_W'(0)};

    typedef enum logic [2:0] {
        S_HDR, S_OFS, S_LEN, S_WDATA, S_RADDR, S_RCAP, S_RSEND, S_ACK
    } state_t;

    state_t           state;
    logic             is_wr;
    logic [SEG_W-1:0] seg;
    logic [OFS_W-1:0] ofs;
    logic [OFS_W-1:0] ofs_inc;
    logic [7:0]       cnt;
    logic             in_fire;
    logic             out_fire;
    logic             unused_rsvd;

    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign ofs_inc     = ofs + OFS_W'(1);
    assign unused_rsvd = in_data[4];

    // Bus outputs default to the parked address with no strobe every cycle;
    // only access cycles override them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_HDR;
            is_wr     <= 1'b0;
            seg       <= '0;
            ofs       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            dbg_addr  <= PARK_ADDR;
            dbg_wen   <= 1'b0;
            dbg_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            dbg_wen  <= 1'b0;
            dbg_addr <= PARK_ADDR;
            case (state)
                S_HDR: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        is_wr <= in_data[7];
                        seg   <= SEG_W'(in_data[6:5]);
                        ofs   <= OFS_W'({in_data[3:0], 8'h00});
                        busy  <= 1'b1;
                        state <= S_OFS;
                    end
                end
                S_OFS: begin
                    if (in_fire) begin
                        ofs   <= ofs | OFS_W'(in_data);
                        state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (in_fire) begin
                        cnt <= in_data;
                        if (is_wr) begin
                            state <= S_WDATA;
                        end else begin
                            in_ready <= 1'b0;
                            dbg_addr <= {seg, ofs};
                            state    <= S_RADDR;
                        end
                    end
                end
                S_WDATA: begin
                    if (in_fire) begin
                        dbg_wen   <= 1'b1;
                        dbg_addr  <= {seg, ofs};
                        dbg_wdata <= in_data;
                        ofs       <= ofs_inc;
                        if (cnt == 8'd0) begin
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= ACK_BYTE;
                            state     <= S_ACK;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                S_RADDR: begin
                    dbg_addr <= {seg, ofs};
                    state    <= S_RCAP;
                end
                S_RCAP: begin
                    out_data  <= dbg_rdata;
                    out_valid <= 1'b1;
                    state     <= S_RSEND;
                end
                S_RSEND: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (cnt != 8'd0) begin
                            cnt      <= cnt - 8'd1;
                            ofs      <= ofs_inc;
                            dbg_addr <= {seg, ofs_inc};
                            state    <= S_RADDR;
                        end else begin
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_HDR;
                        end
                    end
                end
                S_ACK: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_host.sv
// Bench for dbg_host: frame-level model of expected bus writes and returned
// bytes, checked every cycle, plus hand-computed literal expectations.
module tb_dbg_host;

    localparam int unsigned SEG_W = 2;
    localparam int unsigned OFS_W = 12;
    localparam int unsigned AW    = SEG_W + OFS_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] dbg_addr;
    logic          dbg_wen;
    logic [7:0]    dbg_wdata;
    logic [7:0]    dbg_rdata;
    logic          busy;

    always #5 clk = ~clk;

    dbg_host #(.SEG_W(SEG_W), .OFS_W(OFS_W), .PARK_SEG(0), .ACK_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .dbg_addr(dbg_addr), .dbg_wen(dbg_wen), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .busy(busy)
    );

    // Responder: registered read data, a fixed function of the address.
    function automatic logic [7:0] resp(input logic [AW-1:0] a);
        return 8'(32'(a[11:0]) * 7 + 32'(a[13:12]) * 64 + 3);
    endfunction

    always @(posedge clk) dbg_rdata <= resp(dbg_addr);

    // Expectation queues (stimulus writes *_wr, compare process owns *_rd).
    logic [AW-1:0] wq_addr [512];
    logic [7:0]    wq_data [512];
    int            wq_wr = 0, wq_rd = 0;
    logic [7:0]    oq [512];
    int            oq_wr = 0, oq_rd = 0;

    // Literal expectations posted by stimulus, evaluated by the compare process.
    string         lit_name [128];
    logic [31:0]   lit_act  [128];
    logic [31:0]   lit_exp  [128];
    int            lit_n = 0, lit_done = 0;

    int            checks = 0, errors = 0;
    int            wen_total = 0, out_total = 0, run = 0, last_run = 0, since_rst = 0;
    logic [AW-1:0] last_wen_addr = '0;
    logic [7:0]    last_wen_data = '0, last_out = '0, prev_od = '0;
    logic          prev_ov = 1'b0, prev_or = 1'b0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            run = 0;
            since_rst = 0;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_dbg_wen", 32'(dbg_wen), 32'd0);
            chk("rst_dbg_wdata", 32'(dbg_wdata), 32'd0);
            chk("rst_dbg_addr", 32'(dbg_addr), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end else begin
            since_rst++;
            if (dbg_wen) begin
                wen_total++;
                run++;
                last_wen_addr = dbg_addr;
                last_wen_data = dbg_wdata;
                if (wq_rd == wq_wr) begin
                    chk("unexpected_wen", 32'(dbg_wen), 32'd0);
                end else begin
                    chk("wr_addr", 32'(dbg_addr), 32'(wq_addr[wq_rd]));
                    chk("wr_data", 32'(dbg_wdata), 32'(wq_data[wq_rd]));
                    wq_rd++;
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
            end
            if (out_valid && out_ready) begin
                out_total++;
                last_out = out_data;
                if (oq_rd == oq_wr) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_byte", 32'(out_data), 32'(oq[oq_rd]));
                    oq_rd++;
                end
            end
            if (prev_ov && !prev_or) begin
                chk("out_hold_valid", 32'(out_valid), 32'd1);
                chk("out_hold_data", 32'(out_data), 32'(prev_od));
            end
            if (!busy) begin
                chk("idle_addr", 32'(dbg_addr), 32'd0);
                chk("idle_wen", 32'(dbg_wen), 32'd0);
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                if (since_rst >= 2) chk("idle_in_ready", 32'(in_ready), 32'd1);
            end
        end
        while (lit_done < lit_n) begin
            chk(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
            lit_done++;
        end
        prev_ov = out_valid;
        prev_or = out_ready;
        prev_od = out_data;
    end

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        if (lit_n < 128) begin
            lit_name[lit_n] = nm;
            lit_act[lit_n]  = a;
            lit_exp[lit_n]  = e;
            lit_n++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one byte; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick(1);
        end
        if (!done) lit("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_outs(input int target);
        int k = 0;
        while (out_total < target && k < 300) begin
            tick(1);
            k++;
        end
        if (out_total < target) lit("out_timeout", 32'(out_total), 32'(target));
    endtask

    task automatic write_frame(input logic [1:0] sg, input logic [11:0] o, input int n,
                               input logic [7:0] base, input logic rsvd);
        for (int i = 0; i < n; i++) begin
            wq_addr[wq_wr] = {sg, 12'((32'(o) + i) % 4096)};
            wq_data[wq_wr] = 8'(32'(base) + i);
            wq_wr++;
        end
        oq[oq_wr] = 8'hA5;
        oq_wr++;
        send_byte({1'b1, sg, rsvd, o[11:8]});
        lit("hdr_busy", 32'(busy), 32'd1);
        send_byte(o[7:0]);
        send_byte(8'(n - 1));
        for (int i = 0; i < n; i++) send_byte(8'(32'(base) + i));
        lit("wr_latency", 32'(dbg_wen), 32'd1);
        in_valid = 1'b0;
        wait_outs(oq_wr);
        tick(2);
    endtask

    task automatic read_frame(input logic [1:0] sg, input logic [11:0] o, input int n);
        for (int i = 0; i < n; i++) begin
            oq[oq_wr] = resp({sg, 12'((32'(o) + i) % 4096)});
            oq_wr++;
        end
        send_byte({1'b0, sg, 1'b0, o[11:8]});
        send_byte(o[7:0]);
        send_byte(8'(n - 1));
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, o0, k;
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        tick(3);
        lit("rst_hold_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        tick(3);
        lit("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single CTL write
        w0 = wen_total;
        write_frame(2'd0, 12'h000, 1, 8'h11, 1'b0);
        lit("single_wen_count", 32'(wen_total - w0), 32'd1);
        lit("single_addr", 32'(last_wen_addr), 32'h0000);
        lit("single_data", 32'(last_wen_data), 32'h11);
        lit("single_ack", 32'(last_out), 32'hA5);
        lit("single_run", 32'(last_run), 32'd1);

        // ROM burst, back-to-back
        w0 = wen_total;
        write_frame(2'd1, 12'h010, 4, 8'hC0, 1'b0);
        lit("rom_wen_count", 32'(wen_total - w0), 32'd4);
        lit("rom_consecutive", 32'(last_run), 32'd4);
        lit("rom_last_addr", 32'(last_wen_addr), 32'h1013);
        lit("rom_last_data", 32'(last_wen_data), 32'hC3);

        // Idle parking
        tick(20);
        lit("idle_busy", 32'(busy), 32'd0);
        lit("idle_park", 32'(dbg_addr), 32'd0);

        // Read burst with backpressure
        w0 = wen_total; o0 = out_total;
        out_ready = 1'b0;
        read_frame(2'd0, 12'h002, 2);
        k = 0;
        while (!out_valid && k < 50) begin
            tick(1);
            k++;
        end
        lit("read_latency", 32'(k), 32'd2);
        tick(5);
        out_ready = 1'b1;
        wait_outs(o0 + 2);
        tick(2);
        lit("rd_no_wen", 32'(wen_total - w0), 32'd0);
        lit("rd_pc_hi", 32'(last_out), 32'h18);
        lit("rd_model_pc_lo", 32'(oq[oq_wr-2]), 32'h11);

        // Offset wrap with reserved header bit set
        w0 = wen_total;
        write_frame(2'd2, 12'hFFF, 2, 8'h3C, 1'b1);
        lit("wrap_wen_count", 32'(wen_total - w0), 32'd2);
        lit("wrap_last_addr", 32'(last_wen_addr), 32'h2000);
        lit("wrap_model_first", 32'(wq_addr[wq_wr-2]), 32'h2FFF);

        // Reset in the middle of a 4-beat write
        wq_addr[wq_wr] = {2'd1, 12'h020};
        wq_data[wq_wr] = 8'h71;
        wq_wr++;
        send_byte(8'hA0);
        send_byte(8'h20);
        send_byte(8'h03);
        send_byte(8'h71);
        send_byte(8'h72);
        lit("abort_wen_before", 32'(dbg_wen), 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        lit("abort_wen_drop", 32'(dbg_wen), 32'd0);
        lit("abort_out_valid", 32'(out_valid), 32'd0);
        lit("abort_park", 32'(dbg_addr), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        o0 = out_total;
        read_frame(2'd0, 12'h005, 1);
        wait_outs(o0 + 1);
        tick(10);
        lit("post_abort_outs", 32'(out_total - o0), 32'd1);
        lit("post_abort_byte", 32'(last_out), 32'h26);
        lit("post_abort_idle", 32'(busy), 32'd0);

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
